score_keeper: RTL and testbench
===============================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 10, points needed to win; legal range 1..10.
REQ-002 SHALL have parameter HOLD_CYCLES, default 50_000_000, post-point pause length in clocks; minimum 1.
REQ-003 SHALL have parameter RESTART_CYCLES, default 150_000_000, game-over display time before auto-restart; minimum 1.
REQ-004 SHALL have port clock  input  1  single system clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  level, synchronous; starts a game.
REQ-007 SHALL have port pointP1  input  1  level from the ball logic; a rising edge awards player 1 a point.
REQ-008 SHALL have port pointP2  input  1  level from the ball logic; a rising edge awards player 2 a point.
REQ-009 SHALL have port score1  output  4  player 1 score, unsigned 0..WIN_SCORE; feeds an LED bar stage.
REQ-010 SHALL have port score2  output  4  player 2 score, unsigned 0..WIN_SCORE.
REQ-011 SHALL have port ballEnable  output  1  high only in PLAY.
REQ-012 SHALL have port gameOver  output  1  high only in OVER.
REQ-013 SHALL have port winner  output  1  0 = player 1 won, 1 = player 2 won; valid only while gameOver = 1.

Function
REQ-014 SHALL implement FSM states IDLE, PLAY, HOLD and OVER.
REQ-015 SHALL edge-detect pointP1 and pointP2 with one register stage each; a point event is input = 1 with previous sample = 0.
REQ-016 In IDLE, start = 1 SHALL clear both scores and go to PLAY on the next edge.
REQ-017 In PLAY, a single point event SHALL increment that player's score and go to HOLD in the same edge; score and state update together, one-cycle latency.
REQ-018 Point events for both players in the same cycle SHALL be a let: no score change, state stays PLAY.
REQ-019 Point events outside PLAY SHALL be ignored, and SHALL NOT be queued.
REQ-020 When an increment makes a score equal WIN_SCORE, the block SHALL go to OVER instead of HOLD and set winner accordingly.
REQ-021 Scores SHALL saturate at WIN_SCORE and never wrap.
REQ-022 HOLD SHALL last exactly HOLD_CYCLES clocks, counted by a down-counter loaded on entry, then return to PLAY.
REQ-023 In OVER, scores and winner SHALL stay frozen.
REQ-024 start in PLAY or HOLD SHALL be ignored.

Reset
REQ-025 Asserting reset SHALL immediately set: state IDLE; score1 = 0; score2 = 0; ballEnable = 0; gameOver = 0; winner = 0; counters = 0; edge-detect registers = 0.
REQ-026 Reset in any state, including mid-HOLD or mid-OVER, SHALL abort the operation with no residual count.
REQ-027 After reset, a point input held high SHALL NOT generate an event until it goes low and then high again.

Configuration
REQ-028 Macro SCORE_KEEPER_AUTO_RESTART_EN SHALL control how OVER is left.
REQ-029 With the macro defined, OVER SHALL last RESTART_CYCLES clocks, then go to IDLE with scores cleared; start during OVER SHALL also go to IDLE immediately.
REQ-030 Without the macro, OVER SHALL persist until start = 1, which SHALL go to IDLE with scores cleared; the restart counter SHALL NOT be built.

Structure
REQ-031 The shared package pong_pkg SHALL hold the FSM state encoding, the 4-bit score width constant and the maximum-score constant (10).
REQ-032 The shared counter SHALL be one sub-module, hold_timer: loadable down-counter with a done flag, reused for HOLD and OVER.
REQ-033 The score registers, FSM and edge detectors SHALL stay in score_keeper.

Verification
REQ-034 Reset, then start high for 1 cycle -> next cycle ballEnable = 1 with score1 = score2 = 0.
REQ-035 HOLD_CYCLES = 4; one rising edge on pointP1 in PLAY -> next cycle score1 = 1 and ballEnable = 0; ballEnable = 1 again exactly 4 cycles later.
REQ-036 pointP1 and pointP2 rising in the same cycle -> scores unchanged and ballEnable stays 1.
REQ-037 WIN_SCORE = 3; three pointP2 events -> score2 = 3, gameOver = 1, winner = 1; a further pointP2 edge -> score2 stays 3.
REQ-038 pointP1 held high across reset release -> no increment; falling then rising edge after start -> score1 = 1.
REQ-039 Macro defined with RESTART_CYCLES = 5 -> IDLE with scores 0 five cycles after OVER entry; macro undefined -> still OVER after 100 cycles, then start -> IDLE.

Source files
------------

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared Pong scoring types and constants
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HOLD = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam int SCORE_W   = 4;
  localparam int MAX_SCORE = 10;

endpackage

// File: rtl/hold_timer.sv
// rtl/hold_timer.sv - loadable down-counter, done while the count sits at zero
module hold_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - two-player Pong score FSM (IDLE/PLAY/HOLD/OVER)
// SCORE_KEEPER_AUTO_RESTART_EN: leave OVER automatically after RESTART_CYCLES
module score_keeper
  import pong_pkg::*;
#(
  parameter int WIN_SCORE      = 10,
  parameter int HOLD_CYCLES    = 50_000_000,
  parameter int RESTART_CYCLES = 150_000_000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         pointP1,
  input  logic         pointP2,
  output logic [3:0]   score1,
  output logic [3:0]   score2,
  output logic         ballEnable,
  output logic         gameOver,
  output logic         winner
);

  // The timer only has to span the restart pause when that feature exists.
`ifdef SCORE_KEEPER_AUTO_RESTART_EN
  localparam int MAX_CYC = (RESTART_CYCLES > HOLD_CYCLES) ? RESTART_CYCLES : HOLD_CYCLES;
`else
  localparam int MAX_CYC = HOLD_CYCLES;
`endif
  localparam int TW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
`ifdef SCORE_KEEPER_AUTO_RESTART_EN
  localparam logic [TW-1:0] RESTART_LOAD = TW'(RESTART_CYCLES - 1);
`endif
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

  state_t             state, state_n;
  logic [SCORE_W-1:0] s1_q, s2_q, s1_n, s2_n;
  logic               win_q, win_n;
  logic               p1_q, p2_q;
  logic               ev1, ev2;
  logic               tmr_load, tmr_done;
  logic [TW-1:0]      tmr_value;

  assign ev1 = pointP1 & ~p1_q;
  assign ev2 = pointP2 & ~p2_q;

  hold_timer #(.WIDTH(TW)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .done       (tmr_done)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      s1_q  <= '0;
      s2_q  <= '0;
      win_q <= 1'b0;
      p1_q  <= 1'b0;
      p2_q  <= 1'b0;
    end else begin
      state <= state_n;
      s1_q  <= s1_n;
      s2_q  <= s2_n;
      win_q <= win_n;
      p1_q  <= pointP1;
      p2_q  <= pointP2;
    end
  end

  always_comb begin
    state_n   = state;
    s1_n      = s1_q;
    s2_n      = s2_q;
    win_n     = win_q;
    tmr_load  = 1'b0;
    tmr_value = HOLD_LOAD;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = PLAY;
          s1_n    = '0;
          s2_n    = '0;
          win_n   = 1'b0;
        end
      end
      PLAY: begin
        // Simultaneous points cancel out; only a lone event scores.
        if (ev1 ^ ev2) begin
          if (ev1 && s1_q < WIN) s1_n = s1_q + SCORE_W'(1);
          if (ev2 && s2_q < WIN) s2_n = s2_q + SCORE_W'(1);
          tmr_load = 1'b1;
          if ((ev1 && s1_n == WIN) || (ev2 && s2_n == WIN)) begin
            state_n = OVER;
            win_n   = ev2;
`ifdef SCORE_KEEPER_AUTO_RESTART_EN
            tmr_value = RESTART_LOAD;
`endif
          end else begin
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        if (tmr_done) state_n = PLAY;
      end
      OVER: begin
`ifdef SCORE_KEEPER_AUTO_RESTART_EN
        if (start || tmr_done) begin
`else
        if (start) begin
`endif
          state_n = IDLE;
          s1_n    = '0;
          s2_n    = '0;
          win_n   = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign score1     = s1_q;
  assign score2     = s2_q;
  assign ballEnable = (state == PLAY);
  assign gameOver   = (state == OVER);
  assign winner     = win_q;

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - directed vector bench for score_keeper (WIN 3, HOLD 4, RESTART 5)
module tb_score_keeper;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       pointP1;
  logic       pointP2;
  logic [3:0] score1;
  logic [3:0] score2;
  logic       ballEnable;
  logic       gameOver;
  logic       winner;

  int n_checks = 0;
  int n_fail   = 0;

  score_keeper #(
    .WIN_SCORE      (3),
    .HOLD_CYCLES    (4),
    .RESTART_CYCLES (5)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .pointP1    (pointP1),
    .pointP2    (pointP2),
    .score1     (score1),
    .score2     (score2),
    .ballEnable (ballEnable),
    .gameOver   (gameOver),
    .winner     (winner)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       st;
    logic       p1;
    logic       p2;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       ball;
    logic       over;
    logic       win;
  } vec_t;

  vec_t vecs[27];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic st, input logic p1, input logic p2);
    start   = st;
    pointP1 = p1;
    pointP2 = p2;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_state(input string tag, input int s1, input int s2, input int ball, input int over);
    chk({tag, " score1"}, int'(score1), s1);
    chk({tag, " score2"}, int'(score2), s2);
    chk({tag, " ballEnable"}, int'(ballEnable), ball);
    chk({tag, " gameOver"}, int'(gameOver), over);
  endtask

  initial begin
    //           st  p1  p2  s1 s2 ball over win
    vecs[0]  = '{0, 1, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 1, 0, 0, 0, 1, 0, 0};
    vecs[2]  = '{0, 1, 0, 0, 0, 1, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 0, 1, 0, 0};
    vecs[4]  = '{0, 1, 0, 1, 0, 0, 0, 0};
    vecs[5]  = '{0, 1, 0, 1, 0, 0, 0, 0};
    vecs[6]  = '{0, 0, 0, 1, 0, 0, 0, 0};
    vecs[7]  = '{0, 1, 0, 1, 0, 0, 0, 0};
    vecs[8]  = '{0, 1, 0, 1, 0, 1, 0, 0};
    vecs[9]  = '{0, 0, 0, 1, 0, 1, 0, 0};
    vecs[10] = '{0, 1, 1, 1, 0, 1, 0, 0};
    vecs[11] = '{1, 0, 0, 1, 0, 1, 0, 0};
    vecs[12] = '{0, 0, 1, 1, 1, 0, 0, 0};
    vecs[13] = '{1, 0, 0, 1, 1, 0, 0, 0};
    vecs[14] = '{0, 0, 0, 1, 1, 0, 0, 0};
    vecs[15] = '{0, 0, 0, 1, 1, 0, 0, 0};
    vecs[16] = '{0, 0, 0, 1, 1, 1, 0, 0};
    vecs[17] = '{0, 0, 1, 1, 2, 0, 0, 0};
    vecs[18] = '{0, 0, 0, 1, 2, 0, 0, 0};
    vecs[19] = '{0, 0, 0, 1, 2, 0, 0, 0};
    vecs[20] = '{0, 0, 0, 1, 2, 0, 0, 0};
    vecs[21] = '{0, 0, 0, 1, 2, 1, 0, 0};
    vecs[22] = '{0, 0, 1, 1, 3, 0, 1, 1};
    vecs[23] = '{0, 0, 0, 1, 3, 0, 1, 1};
    vecs[24] = '{0, 0, 1, 1, 3, 0, 1, 1};
    vecs[25] = '{0, 0, 0, 1, 3, 0, 1, 1};
    vecs[26] = '{0, 0, 0, 1, 3, 0, 1, 1};

    reset   = 1'b1;
    start   = 1'b0;
    pointP1 = 1'b1;
    pointP2 = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk_state("reset", 0, 0, 0, 0);
    chk("reset winner", int'(winner), 0);
    reset = 1'b0;

    // pointP1 stays high across reset release and must not score
    for (int i = 0; i < 27; i++) begin
      step(vecs[i].st, vecs[i].p1, vecs[i].p2);
      chk_state($sformatf("row%0d", i), vecs[i].s1, vecs[i].s2, vecs[i].ball, vecs[i].over);
      if (vecs[i].over) chk($sformatf("row%0d winner", i), int'(winner), vecs[i].win);
    end

`ifdef SCORE_KEEPER_AUTO_RESTART_EN
    step(0, 0, 0);
    chk_state("auto restart", 0, 0, 0, 0);
    step(1, 0, 0);
    chk_state("restart start", 0, 0, 1, 0);
`else
    repeat (100) step(0, 0, 0);
    chk_state("over persists", 1, 3, 0, 1);
    chk("over persists winner", int'(winner), 1);
    step(1, 0, 0);
    chk_state("over start", 0, 0, 0, 0);
    step(1, 0, 0);
    chk_state("restart start", 0, 0, 1, 0);
`endif

    // Reset in the middle of HOLD, then a full HOLD must still last 4 cycles
    step(0, 1, 0);
    chk_state("pre-reset point", 1, 0, 0, 0);
    step(0, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk_state("async reset", 0, 0, 0, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    step(1, 0, 0);
    chk_state("post-reset start", 0, 0, 1, 0);
    step(0, 1, 0);
    chk_state("post-reset point", 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0);
      chk($sformatf("post-reset hold%0d ballEnable", i), int'(ballEnable), 0);
    end
    step(0, 0, 0);
    chk("post-reset hold end ballEnable", int'(ballEnable), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
